// File: rtl/modport_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modport_fifo_pkg
// Description : Shared defaults and helper types for the modport_fifo block.
//               FIFO_DATA_W / FIFO_DEPTH are the default word width and entry
//               count. FIFO_PTR_W is the matching pointer width. fifo_op_e
//               names the four combinations of accepted write and read in
//               one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package modport_fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_PTR_W  = $clog2(FIFO_DEPTH);

  // Encoding is {read, write} so the decode below is a plain concatenation.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({rd_acc, wr_acc});
  endfunction

endpackage : modport_fifo_pkg
`default_nettype wire

// File: rtl/modport_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x DATA_W storage array for modport_fifo.
//               The write port is synchronous. The read address is decoded
//               combinationally, so a read and a write to the same entry in
//               one cycle return the old contents. The array has no reset.
// Ports       : clk      - clock
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               raddr_i  - read address
//               rdata_o  - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/modport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : modport_fifo
// Description : Single-clock synchronous FIFO with registered read data.
//               The pointers, occupancy counter and flags live here. Storage
//               is in fifo_mem.
// Ports       : clk    - clock; all state changes on the rising edge
//               rst    - asynchronous active-high reset
//               w_en   - write request
//               r_en   - read request
//               wdata  - write data
//               rdata  - registered read data; holds until the next read is
//                        accepted
//               full   - DEPTH entries stored
//               empty  - no entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module modport_fifo
  import modport_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_acc;
  logic              wr_acc;
  fifo_op_e          op;

  // A write is accepted into a full FIFO only when a read frees a slot on the
  // same edge.
  assign rd_acc = r_en && !empty;
  assign wr_acc = w_en && (!full || rd_acc);
  assign op     = decode_op(wr_acc, rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 on
    // their own.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      rdata_d  = mem_rdata;
    end
    case (op)
      OP_WRITE: count_d = count_q + CNT_W'(1);
      OP_READ:  count_d = count_q - CNT_W'(1);
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Gating the write with rst means an edge that coincides with reset leaves
  // the array untouched.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign rdata = rdata_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule : modport_fifo
`default_nettype wire

// File: tb/tb_modport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_modport_fifo
// Description : Self-checking bench for modport_fifo. A queue-based reference
//               model predicts rdata, full and empty after every clock edge.
//               The sequence runs fill/drain, overflow, underflow,
//               simultaneous access at both extremes, wrap-around, random
//               traffic and an asynchronous mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_en;
  logic              r_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_rdata;
  logic [DATA_W-1:0] popped [$];

  modport_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .w_en  (w_en),
    .r_en  (r_en),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rdata"}, 32'(rdata), 32'(exp_rdata));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // Drive one cycle, update the model from its pre-edge occupancy, then check.
  task automatic cycle(input logic w, input logic r, input logic [DATA_W-1:0] d,
                       input string tag);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    w_en  = w;
    r_en  = r;
    wdata = d;
    @(posedge clk);
    rd_ok = r && (model_q.size() > 0);
    wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) begin
      exp_rdata = model_q.pop_front();
      popped.push_back(exp_rdata);
    end
    if (wr_ok) model_q.push_back(d);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    rst   = 1'b1;
    w_en  = 1'b0;
    r_en  = 1'b0;
    wdata = '0;
    exp_rdata = '0;

    // Reset state, before any clock edge.
    #2;
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full",  32'(full),  32'd0);
    check("reset.rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Fill with 0x01..0x08.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DATA_W'(i), "fill");
    check("fill.full_after_8", 32'(full), 32'd1);

    // Overflow: this write must be dropped.
    cycle(1'b1, 1'b0, 8'hAA, "overflow");

    // Drain: expect 0x01..0x08 in order, with no 0xAA.
    popped.delete();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00, "drain");
      check("drain.value", 32'(rdata), 32'(i));
    end
    check("drain.empty", 32'(empty), 32'd1);

    // Underflow: rdata holds 0x08 and empty stays 1.
    cycle(1'b0, 1'b1, 8'h00, "underflow");
    check("underflow.hold", 32'(rdata), 32'h08);

    // Simultaneous access while empty: only the write takes effect.
    cycle(1'b1, 1'b1, 8'h33, "both_empty");
    check("both_empty.rdata", 32'(rdata), 32'h08);
    check("both_empty.not_empty", 32'(empty), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 1'b0, DATA_W'(8'h40 + i), "refill");

    // Simultaneous access while full: the oldest word comes out and full stays 1.
    cycle(1'b1, 1'b1, 8'h55, "both_full");
    check("both_full.oldest", 32'(rdata), 32'h33);
    check("both_full.full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, "drain2");
    check("drain2.last_is_55", 32'(rdata), 32'h55);

    // Wrap-around: 20 write/read pairs.
    for (int i = 0; i < 20; i++) begin
      d = DATA_W'($urandom);
      cycle(1'b1, 1'b0, d, "wrap.w");
      cycle(1'b0, 1'b1, 8'h00, "wrap.r");
      check("wrap.value", 32'(rdata), 32'(d));
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), DATA_W'($urandom), "random");
    end

    // Make sure something is stored, then assert reset between edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DATA_W'($urandom_range(1, 255)), "prereset");
    @(negedge clk);
    w_en = 1'b1;
    r_en = 1'b1;
    wdata = 8'h77;
    #2 rst = 1'b1;
    #1;
    check("async_rst.empty", 32'(empty), 32'd1);
    check("async_rst.full",  32'(full),  32'd0);
    check("async_rst.rdata", 32'(rdata), 32'd0);
    model_q.delete();
    exp_rdata = '0;
    // An edge while rst is high must be ignored even with requests present.
    @(posedge clk);
    #1;
    check("rst_edge.empty", 32'(empty), 32'd1);
    check("rst_edge.rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
    #2 rst = 1'b0;

    // Operation resumes after reset.
    cycle(1'b1, 1'b0, 8'h5A, "resume.w");
    cycle(1'b0, 1'b1, 8'h00, "resume.r");
    check("resume.value", 32'(rdata), 32'h5A);
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom), 1'($urandom), DATA_W'($urandom), "random2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_modport_fifo
`default_nettype wire
